arm_alu_seq: RTL
================

Name: arm_alu_seq

Overview:
- Registered, parametrised successor of the combinational ARM ALU datapath.
- Executes the ARM data-processing opcode set at WIDTH bits, plus a multi-cycle MUL, behind a valid/ready input handshake.
- Holds the NZCV flag register internally, with ARM-correct carry/overflow and S-controlled flag update.
- Sits between the register-file read ports and the write-back bus; the result drives the shared bus through a tri-state enable.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- CNT_W, 6, MUL iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; = (state==IDLE)
- op  in  5  opcode, sampled at accept
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (shifter operand)
- s  in  1  set-flags bit, sampled at accept
- flags_load  in  1  overwrite flag register (MSR path)
- flags_in  in  4  NZCV value for flags_load
- out_en  in  1  drive result onto bus
- result  out  WIDTH  registered result; high-Z when out_en=0
- out_valid  out  1  one-cycle pulse: result/flags updated this cycle
- flags  out  4  registered {N,Z,C,V}
- illegal_op  out  1  one-cycle pulse with out_valid for an undefined opcode

Behaviour:
- Reset (async, rst_n=0): state=IDLE, internal result=0, flags=0, out_valid=0, illegal_op=0, MUL counter/partials=0. in_ready=1 while in IDLE. Reset during MUL aborts it with no out_valid.
- Accept occurs on a clock edge with in_valid & in_ready. Operands, op and s are captured only at accept.
- Opcodes:
  - 00000 AND; 00001 EOR; 00010 SUB A-B; 00011 RSB B-A
  - 00100 ADD; 00101 ADC A+B+C; 00110 SBC A-B-!C; 00111 RSC B-A-!C
  - 01000 TST; 01001 TEQ; 01010 CMP; 01011 CMN
  - 01100 ORR; 01101 MOV (A); 01110 BIC A&~B; 01111 MVN ~B
  - 10000 pass B; 10001 A+4; 10010 pass A; 10011 MUL (low WIDTH bits of A*B)
  - All other codes: illegal.
- Single-cycle ops: the result register and flags update on the accept edge; out_valid=1 the following cycle. State stays IDLE, so back-to-back accepts give one op per cycle.
- C used by ADC/SBC/RSC is the flag register value at the accept edge. It therefore already reflects a flag-setting op accepted on the previous cycle (no stall).
- Compare ops (TST/TEQ/CMP/CMN): result register unchanged; flags always updated regardless of s; out_valid still pulses.
- Flag rules, applied when s=1 or the op is a compare:
  - N = res[WIDTH-1]; Z = (res==0).
  - Arithmetic ops: C = carry out of the WIDTH-bit add, with subtraction done as X+~Y+1, so C=1 means no borrow. V = signed overflow of that add.
  - Logical, move, MUL and pass ops: C and V preserved.
  - Ops 10000/10001/10010 never touch flags, even with s=1.
- MUL: accept moves state IDLE->MUL with counter=0, acc=0, mcand=a, mplier=b. Each cycle: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; counter++. After WIDTH iterations, acc is written to the result (and N/Z if s=1) and state returns to IDLE; out_valid pulses the next cycle. Accept-to-out_valid latency = WIDTH+1 cycles; in_ready=0 for WIDTH cycles.
- Illegal op: result and flags unchanged; out_valid and illegal_op pulse together the next cycle.
- flags_load on the same edge as a flag update: flags_load wins.
- out_en is combinational to result only. It does not affect internal state.

Test Plan:
- Reset, then ADD a=32'hFFFF_FFFF, b=1, s=1 -> next cycle out_valid=1, result=0, flags=4'b0110 (Z,C).
- SUBS a=5, b=7 -> result=32'hFFFF_FFFE, N=1, C=0, V=0; then CMP a=32'h8000_0000, b=1 -> result unchanged, flags V=1, C=1, N=0, Z=0.
- ADDS a=32'hFFFF_FFFF, b=2 (C=1), then ADC a=b=0 accepted the very next cycle -> result=1, both out_valid pulses in consecutive cycles.
- MUL a=1234, b=5678, s=1 -> in_ready low 32 cycles, out_valid at accept+33, result=7006652, N=0, Z=0, C/V preserved.
- Pull rst_n low at MUL iteration 10 -> everything zero immediately; no out_valid; new ADD accepted after release works normally.
- op=5'b11111 -> illegal_op and out_valid pulse, flags unchanged; flags_load=1 with flags_in=4'b1010 on the same edge as ANDS -> flags=4'b1010; out_en=0 -> result reads high-Z.

Source files
------------

// File: rtl/arm_alu_seq.sv
// Registered ARM data-processing ALU with NZCV flags and a
// shift-add multi-cycle MUL behind a valid/ready handshake.
module arm_alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             flags_load,
  input  logic [3:0]       flags_in,
  input  logic             out_en,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic [3:0]       flags,
  output logic             illegal_op
);

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_EOR = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_RSB = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_ADC = 5'b00101;
  localparam logic [4:0] OP_SBC = 5'b00110;
  localparam logic [4:0] OP_RSC = 5'b00111;
  localparam logic [4:0] OP_TST = 5'b01000;
  localparam logic [4:0] OP_TEQ = 5'b01001;
  localparam logic [4:0] OP_CMP = 5'b01010;
  localparam logic [4:0] OP_CMN = 5'b01011;
  localparam logic [4:0] OP_ORR = 5'b01100;
  localparam logic [4:0] OP_MOV = 5'b01101;
  localparam logic [4:0] OP_BIC = 5'b01110;
  localparam logic [4:0] OP_MVN = 5'b01111;
  localparam logic [4:0] OP_PSB = 5'b10000;
  localparam logic [4:0] OP_A4  = 5'b10001;
  localparam logic [4:0] OP_PSA = 5'b10010;
  localparam logic [4:0] OP_MUL = 5'b10011;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_out_valid;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic             r_mul_s;

  logic             w_accept;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_ci;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_arith;
  logic             w_logic;
  logic             w_cmp;
  logic             w_mul;
  logic             w_ill;
  logic [3:0]       w_op_flags;
  logic [3:0]       w_flags_d;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_acc_nxt;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;

  // Subtraction is X + ~Y + cin so C reads as "no borrow".
  always_comb begin
    w_x     = a;
    w_y     = b;
    w_ci    = 1'b0;
    w_res   = '0;
    w_arith = 1'b0;
    w_logic = 1'b0;
    w_cmp   = 1'b0;
    w_mul   = 1'b0;
    w_ill   = 1'b0;
    case (op)
      OP_AND: begin w_res = a & b; w_logic = 1'b1; end
      OP_EOR: begin w_res = a ^ b; w_logic = 1'b1; end
      OP_SUB: begin w_y = ~b; w_ci = 1'b1; w_arith = 1'b1; end
      OP_RSB: begin
        w_x = b; w_y = ~a; w_ci = 1'b1; w_arith = 1'b1;
      end
      OP_ADD: w_arith = 1'b1;
      OP_ADC: begin w_ci = r_flags[1]; w_arith = 1'b1; end
      OP_SBC: begin
        w_y = ~b; w_ci = r_flags[1]; w_arith = 1'b1;
      end
      OP_RSC: begin
        w_x = b; w_y = ~a; w_ci = r_flags[1]; w_arith = 1'b1;
      end
      OP_TST: begin
        w_res = a & b; w_logic = 1'b1; w_cmp = 1'b1;
      end
      OP_TEQ: begin
        w_res = a ^ b; w_logic = 1'b1; w_cmp = 1'b1;
      end
      OP_CMP: begin
        w_y = ~b; w_ci = 1'b1; w_arith = 1'b1; w_cmp = 1'b1;
      end
      OP_CMN: begin w_arith = 1'b1; w_cmp = 1'b1; end
      OP_ORR: begin w_res = a | b; w_logic = 1'b1; end
      OP_MOV: begin w_res = a; w_logic = 1'b1; end
      OP_BIC: begin w_res = a & ~b; w_logic = 1'b1; end
      OP_MVN: begin w_res = ~b; w_logic = 1'b1; end
      OP_PSB: w_res = b;
      OP_A4:  w_res = a + WIDTH'(4);
      OP_PSA: w_res = a;
      OP_MUL: w_mul = 1'b1;
      default: w_ill = 1'b1;
    endcase
    {w_cout, w_sum} = {1'b0, w_x} + {1'b0, w_y}
                    + {{WIDTH{1'b0}}, w_ci};
    w_ovf = (w_x[WIDTH-1] == w_y[WIDTH-1])
          & (w_sum[WIDTH-1] != w_x[WIDTH-1]);
    if (w_arith) w_res = w_sum;
  end

  always_comb begin
    w_op_flags = r_flags;
    if ((s | w_cmp) & (w_arith | w_logic)) begin
      w_op_flags[3] = w_res[WIDTH-1];
      w_op_flags[2] = (w_res == '0);
      if (w_arith) w_op_flags[1:0] = {w_cout, w_ovf};
    end
  end

  assign w_mul_done = (r_state == S_MUL)
                    & (r_cnt == CNT_W'(WIDTH - 1));
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  // MSR-style flags_load overrides any flag update on the same edge.
  always_comb begin
    w_flags_d = r_flags;
    if (w_accept & ~w_mul & ~w_ill) w_flags_d = w_op_flags;
    if (w_mul_done & r_mul_s) begin
      w_flags_d[3] = w_acc_nxt[WIDTH-1];
      w_flags_d[2] = (w_acc_nxt == '0);
    end
    if (flags_load) w_flags_d = flags_in;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept & w_mul) w_state_nxt = S_MUL;
      S_MUL:  if (w_mul_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_mul_s     <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_flags     <= w_flags_d;
      if (w_accept) begin
        if (w_mul) begin
          r_cnt    <= '0;
          r_acc    <= '0;
          r_mcand  <= a;
          r_mplier <= b;
          r_mul_s  <= s;
        end else begin
          r_out_valid <= 1'b1;
          r_illegal   <= w_ill;
          if (!w_ill && !w_cmp) r_result <= w_res;
        end
      end
      if (r_state == S_MUL) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_mul_done) begin
          r_result    <= w_acc_nxt;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign result     = out_en ? r_result : {WIDTH{1'bz}};
  assign out_valid  = r_out_valid;
  assign flags      = r_flags;
  assign illegal_op = r_illegal;

endmodule
